phy_rx_nlane: RTL

//   Parametrised PHY receive path for NUM_LANES serial lanes in a single clock domain.
//   Per lane: bit deserialiser, comma alignment, a lock FSM, byte-to-word packing and a small FIFO.
//   A round-robin unstriper merges the lane words back into one word stream.

---
 rtl/phy_rx_nlane.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/phy_rx_nlane.sv
// Multi-lane PHY receive path: per-lane deserialiser, comma lock FSM, word packer and FIFO,
// merged by a round-robin unstriper into one valid/ready word stream.
module phy_rx_nlane #(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned WORD_W     = 32,
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] serial_in,
  input  logic                 ready_in,
  output logic [WORD_W-1:0]    data_out,
  output logic                 valid_out,
  output logic [NUM_LANES-1:0] lane_locked,
  output logic                 all_locked,
  output logic [NUM_LANES-1:0] overflow
);

  localparam int unsigned NumBytes = WORD_W / 8;
  localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned LockW    = $clog2(LOCK_CNT + 1);
  localparam int unsigned AddrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned RrW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {StSearch, StLocking, StLocked} lane_state_e;

  logic [WORD_W-1:0]    fifo_head [NUM_LANES];
  logic [NUM_LANES-1:0] fifo_empty;
  logic [NUM_LANES-1:0] pop;
  logic [RrW-1:0]       rr;
  logic                 load;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_state_e       state;
    logic [6:0]        sr;
    logic [2:0]        bit_cnt;
    logic [LockW-1:0]  lock_cnt;
    logic [ByteW-1:0]  byte_idx;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_next;
    logic              push;
    logic [7:0]        cand;
    logic              is_comma;
    logic              boundary;

    assign cand     = {sr, serial_in[i]};
    assign is_comma = (cand == COMMA);
    assign boundary = (bit_cnt == 3'd7);
    assign lane_locked[i] = (state == StLocked);

    // First byte of a word lands in the MSBs.
    always_comb begin
      word_next = word;
      for (int unsigned k = 0; k < NumBytes; k++) begin
        if (byte_idx == ByteW'(k)) word_next[WORD_W-1-8*k -: 8] = cand;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state    <= StSearch;
        sr       <= '0;
        bit_cnt  <= '0;
        lock_cnt <= '0;
        byte_idx <= '0;
        word     <= '0;
        push     <= 1'b0;
      end else begin
        sr      <= cand[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        push    <= 1'b0;
        unique case (state)
          StSearch: begin
            if (is_comma) begin
              bit_cnt  <= 3'd0;
              lock_cnt <= LockW'(1);
              state    <= (LOCK_CNT == 1) ? StLocked : StLocking;
            end
          end
          StLocking: begin
            if (boundary) begin
              if (is_comma) begin
                lock_cnt <= lock_cnt + LockW'(1);
                if (lock_cnt + LockW'(1) == LockW'(LOCK_CNT)) state <= StLocked;
              end else begin
                lock_cnt <= '0;
                state    <= StSearch;
              end
            end
          end
          StLocked: begin
            if (boundary) begin
              if (is_comma) begin
                byte_idx <= '0;
              end else if (byte_idx == ByteW'(NumBytes - 1)) begin
                byte_idx <= '0;
                word     <= word_next;
                push     <= 1'b1;
              end else begin
                byte_idx <= byte_idx + ByteW'(1);
                word     <= word_next;
              end
            end
          end
          default: state <= StSearch;
        endcase
      end
    end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AddrW:0]    wptr;
    logic [AddrW:0]    rptr;
    logic              full;
    logic              wr_en;
    logic              ovf;

    assign fifo_empty[i] = (wptr == rptr);
    assign full          = (wptr[AddrW] != rptr[AddrW]) &&
                           (wptr[AddrW-1:0] == rptr[AddrW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en         = push && (!full || pop[i]);
    assign fifo_head[i]  = mem[rptr[AddrW-1:0]];
    assign overflow[i]   = ovf;

    always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AddrW-1:0]] <= word;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        ovf  <= 1'b0;
      end else begin
        if (wr_en)  wptr <= wptr + {{AddrW{1'b0}}, 1'b1};
        if (pop[i]) rptr <= rptr + {{AddrW{1'b0}}, 1'b1};
        if (push && full && !pop[i]) ovf <= 1'b1;
      end
    end
  end

  assign all_locked = &lane_locked;

  // Strict round robin: waits on an empty lane rather than skipping it.
  always_comb begin
    load = 1'b0;
    pop  = '0;
    if (all_locked && (!valid_out || ready_in) && !fifo_empty[rr]) begin
      load    = 1'b1;
      pop[rr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      rr        <= '0;
    end else if (load) begin
      data_out  <= fifo_head[rr];
      valid_out <= 1'b1;
      rr        <= (rr == RrW'(NUM_LANES - 1)) ? '0 : rr + RrW'(1);
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule
